// File: rtl/hazard_scoreboard_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | hazard_scoreboard_pkg : shared constants for the Tuse/Tnew tracker |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package hazard_scoreboard_pkg;

  // Sized to the user's TW by truncation; -1 gives all-ones at any width.
  localparam int TUSE_NONE = -1;

  typedef struct packed {
    logic        we;
    int unsigned waddr;
    int unsigned tnew;
  } rec_init_t;

  localparam rec_init_t BUBBLE = '{we: 1'b0, waddr: 0, tnew: 0};

  typedef enum int {
    S_E = 1,
    S_M = 2,
    S_W = 3
  } stage_e;

endpackage
`default_nettype wire

// File: rtl/hazard_stage_rec.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | hazard_stage_rec : one in-flight writer record with Tnew aging     |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module hazard_stage_rec
  import hazard_scoreboard_pkg::*;
#(
  parameter int AW = 5,
  parameter int TW = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          bubble,
  input  logic          age,
  input  logic          in_we,
  input  logic [AW-1:0] in_waddr,
  input  logic [TW-1:0] in_tnew,
  output logic          we,
  output logic [AW-1:0] waddr,
  output logic [TW-1:0] tnew
);

  logic [TW-1:0] w_tnew_next;

  always_comb begin
    w_tnew_next = in_tnew;
    if (age && (in_tnew != '0)) w_tnew_next = in_tnew - 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we    <= BUBBLE.we;
      waddr <= AW'(BUBBLE.waddr);
      tnew  <= TW'(BUBBLE.tnew);
    end else if (flush || bubble) begin
      we    <= BUBBLE.we;
      waddr <= AW'(BUBBLE.waddr);
      tnew  <= TW'(BUBBLE.tnew);
    end else begin
      // Writes to $0 are never hazards, so they are tracked as non-writers.
      we    <= in_we && (in_waddr != '0);
      waddr <= in_waddr;
      tnew  <= w_tnew_next;
    end
  end

endmodule
`default_nettype wire

// File: rtl/hazard_scoreboard.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | hazard_scoreboard : D-stage stall / forwarding from Tuse vs Tnew   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int STAGES = 3,
  parameter int AW     = 5,
  parameter int TW     = 3,
  parameter int CW     = 32,
  parameter int SW     = $clog2(STAGES + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          d_valid,
  input  logic [AW-1:0] d_rs,
  input  logic [AW-1:0] d_rt,
  input  logic [TW-1:0] d_tuse_rs,
  input  logic [TW-1:0] d_tuse_rt,
  input  logic          d_we,
  input  logic [AW-1:0] d_waddr,
  input  logic [TW-1:0] d_tnew,
  input  logic          flush,
  output logic          stall,
  output logic [SW-1:0] fwd_rs_d,
  output logic [SW-1:0] fwd_rt_d,
  output logic [CW-1:0] stall_cnt
);

  localparam logic [TW-1:0] C_TUSE_UNUSED = TW'(TUSE_NONE);

  logic [STAGES:1] st_we;
  logic [AW-1:0]   st_waddr [1:STAGES];
  logic [TW-1:0]   st_tnew  [1:STAGES];

  generate
    for (genvar k = 1; k <= STAGES; k++) begin : g_stage
      if (k == 1) begin : g_first
        hazard_stage_rec #(.AW(AW), .TW(TW)) u_rec (
          .clk      (clk),
          .rst_n    (rst_n),
          .flush    (flush),
          .bubble   (stall | ~d_valid),
          .age      (1'b0),
          .in_we    (d_we),
          .in_waddr (d_waddr),
          .in_tnew  (d_tnew),
          .we       (st_we[k]),
          .waddr    (st_waddr[k]),
          .tnew     (st_tnew[k])
        );
      end else begin : g_next
        hazard_stage_rec #(.AW(AW), .TW(TW)) u_rec (
          .clk      (clk),
          .rst_n    (rst_n),
          .flush    (flush),
          .bubble   (1'b0),
          .age      (1'b1),
          .in_we    (st_we[k-1]),
          .in_waddr (st_waddr[k-1]),
          .in_tnew  (st_tnew[k-1]),
          .we       (st_we[k]),
          .waddr    (st_waddr[k]),
          .tnew     (st_tnew[k])
        );
      end
    end
  endgenerate

  logic          w_hit_rs, w_hit_rt;
  logic [SW-1:0] w_k_rs, w_k_rt;
  logic [TW-1:0] w_t_rs, w_t_rt;
  logic          w_stall_rs, w_stall_rt;

  // Scan oldest to youngest so the nearest matching stage wins.
  always_comb begin
    w_hit_rs = 1'b0;
    w_k_rs   = '0;
    w_t_rs   = '0;
    w_hit_rt = 1'b0;
    w_k_rt   = '0;
    w_t_rt   = '0;
    for (int k = STAGES; k >= 1; k--) begin
      if (st_we[k] && (st_waddr[k] == d_rs) && (d_rs != '0)) begin
        w_hit_rs = 1'b1;
        w_k_rs   = SW'(k);
        w_t_rs   = st_tnew[k];
      end
      if (st_we[k] && (st_waddr[k] == d_rt) && (d_rt != '0)) begin
        w_hit_rt = 1'b1;
        w_k_rt   = SW'(k);
        w_t_rt   = st_tnew[k];
      end
    end
  end

  assign w_stall_rs = w_hit_rs && (d_tuse_rs != C_TUSE_UNUSED) && (w_t_rs > d_tuse_rs);
  assign w_stall_rt = w_hit_rt && (d_tuse_rt != C_TUSE_UNUSED) && (w_t_rt > d_tuse_rt);
  assign stall      = d_valid && (w_stall_rs || w_stall_rt);

  assign fwd_rs_d = (d_valid && w_hit_rs && (w_t_rs == '0)) ? w_k_rs : '0;
  assign fwd_rt_d = (d_valid && w_hit_rt && (w_t_rt == '0)) ? w_k_rt : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (stall && !flush && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_hazard_scoreboard.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_hazard_scoreboard : directed bench, 3-stage and 5-stage DUTs    |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_hazard_scoreboard;
  import hazard_scoreboard_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       d_valid, d_we, flush;
  logic [4:0] d_rs, d_rt, d_waddr;
  logic [2:0] d_tuse_rs, d_tuse_rt, d_tnew;

  logic        stall_a, stall_b;
  logic [1:0]  fwd_rs_a, fwd_rt_a;
  logic [2:0]  fwd_rs_b, fwd_rt_b;
  logic [31:0] cnt_a;
  logic [1:0]  cnt_b;

  hazard_scoreboard #(.STAGES(3), .AW(5), .TW(3), .CW(32)) dut_a (
    .clk(clk), .rst_n(rst_n), .d_valid(d_valid), .d_rs(d_rs), .d_rt(d_rt),
    .d_tuse_rs(d_tuse_rs), .d_tuse_rt(d_tuse_rt), .d_we(d_we), .d_waddr(d_waddr),
    .d_tnew(d_tnew), .flush(flush), .stall(stall_a), .fwd_rs_d(fwd_rs_a),
    .fwd_rt_d(fwd_rt_a), .stall_cnt(cnt_a)
  );

  // Narrow counter on the 5-stage copy so saturation is reachable.
  hazard_scoreboard #(.STAGES(5), .AW(5), .TW(3), .CW(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .d_valid(d_valid), .d_rs(d_rs), .d_rt(d_rt),
    .d_tuse_rs(d_tuse_rs), .d_tuse_rt(d_tuse_rt), .d_we(d_we), .d_waddr(d_waddr),
    .d_tnew(d_tnew), .flush(flush), .stall(stall_b), .fwd_rs_d(fwd_rs_b),
    .fwd_rt_d(fwd_rt_b), .stall_cnt(cnt_b)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: each stage holds the instruction's original Tnew; its current
  // Tnew at stage k is max(0, Tnew - (k-1)).
  int     nst [2] = '{3, 5};
  longint cmax[2] = '{64'hFFFF_FFFF, 3};
  bit     mwe  [2][6];
  int     maddr[2][6];
  int     mt0  [2][6];
  longint mcnt [2];

  function automatic int cur_t(input int c, input int k);
    return (mt0[c][k] > k - 1) ? mt0[c][k] - (k - 1) : 0;
  endfunction

  task automatic src_eval(input int c, input int s, input int tuse,
                          output bit st, output int fwd);
    bit found = 0;
    int kk = 0;
    int t = 0;
    for (int k = 1; k <= nst[c]; k++) begin
      if (!found && mwe[c][k] && maddr[c][k] == s && s != 0) begin
        found = 1; kk = k; t = cur_t(c, k);
      end
    end
    st  = d_valid && found && (tuse != 7) && (t > tuse);
    fwd = (d_valid && found && t == 0) ? kk : 0;
  endtask

  task automatic model_outs(input int c, output bit st, output int frs, output int frt);
    bit s1, s2;
    src_eval(c, int'(d_rs), int'(d_tuse_rs), s1, frs);
    src_eval(c, int'(d_rt), int'(d_tuse_rt), s2, frt);
    st = s1 || s2;
  endtask

  task automatic model_clear(input int c);
    for (int k = 0; k < 6; k++) begin
      mwe[c][k] = 0; maddr[c][k] = 0; mt0[c][k] = 0;
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < 2; c++) begin
        model_clear(c);
        mcnt[c] = 0;
      end
    end else begin
      for (int c = 0; c < 2; c++) begin
        bit st;
        int frs, frt;
        model_outs(c, st, frs, frt);
        if (flush) begin
          model_clear(c);
        end else begin
          if (st && mcnt[c] < cmax[c]) mcnt[c]++;
          for (int k = nst[c]; k >= 2; k--) begin
            mwe[c][k] = mwe[c][k-1]; maddr[c][k] = maddr[c][k-1]; mt0[c][k] = mt0[c][k-1];
          end
          if (st || !d_valid) begin
            mwe[c][1] = 0; maddr[c][1] = 0; mt0[c][1] = 0;
          end else begin
            mwe[c][1] = d_we && (d_waddr != 0); maddr[c][1] = int'(d_waddr); mt0[c][1] = int'(d_tnew);
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      bit st;
      int frs, frt;
      model_outs(0, st, frs, frt);
      chk("cmp_stall_a", stall_a, st);
      chk("cmp_fwd_rs_a", fwd_rs_a, frs);
      chk("cmp_fwd_rt_a", fwd_rt_a, frt);
      chk("cmp_cnt_a", cnt_a, mcnt[0]);
      model_outs(1, st, frs, frt);
      chk("cmp_stall_b", stall_b, st);
      chk("cmp_fwd_rs_b", fwd_rs_b, frs);
      chk("cmp_fwd_rt_b", fwd_rt_b, frt);
      chk("cmp_cnt_b", cnt_b, mcnt[1]);
    end
  end

  task automatic setd(input bit v, input int rs, input int trs, input int rt, input int trt,
                      input bit we, input int wa, input int tn);
    d_valid = v; d_rs = 5'(rs); d_tuse_rs = 3'(trs); d_rt = 5'(rt); d_tuse_rt = 3'(trt);
    d_we = we; d_waddr = 5'(wa); d_tnew = 3'(tn);
  endtask

  task automatic idle();
    setd(0, 0, 7, 0, 7, 0, 0, 0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    idle();
    repeat (6) tick();
  endtask

  initial begin
    idle();
    flush = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_stall_a", stall_a, 0);
    chk("rst_fwd_rs_a", fwd_rs_a, 0);
    chk("rst_cnt_a", cnt_a, 0);
    chk("rst_cnt_b", cnt_b, 0);
    rst_n = 1'b1;
    tick();

    // load-use
    setd(1, 0, 7, 0, 7, 1, 1, 2); tick();
    setd(1, 1, 1, 0, 7, 0, 0, 0); #1;
    chk("lu_stall_c1_a", stall_a, 1);
    chk("lu_stall_c1_b", stall_b, 1);
    tick(); #1;
    chk("lu_stall_c2_a", stall_a, 0);
    chk("lu_fwd_c2_a", fwd_rs_a, 0);
    tick(); #1;
    chk("lu_fwd_c3_a", fwd_rs_a, S_W);
    chk("lu_fwd_c3_b", fwd_rs_b, S_W);
    chk("lu_cnt_a", cnt_a, 1);
    chk("lu_cnt_b", cnt_b, 1);
    tick(); drain();

    // ALU to branch
    setd(1, 0, 7, 0, 7, 1, 3, 1); tick();
    setd(1, 3, 0, 0, 7, 0, 0, 0); #1;
    chk("br_stall_c1", stall_a, 1);
    tick(); #1;
    chk("br_stall_c2", stall_a, 0);
    chk("br_fwd_c2_a", fwd_rs_a, S_M);
    chk("br_fwd_c2_b", fwd_rs_b, S_M);
    tick(); drain();

    // jal to jr
    setd(1, 0, 7, 0, 7, 1, 31, 0); tick();
    setd(1, 31, 0, 0, 7, 0, 0, 0); #1;
    chk("jr_stall", stall_a, 0);
    chk("jr_fwd", fwd_rs_a, S_E);
    tick(); drain();

    // shadowing and $0
    setd(1, 0, 7, 0, 7, 1, 5, 0); tick();
    setd(1, 0, 7, 0, 7, 1, 5, 0); tick();
    setd(1, 0, 7, 5, 0, 0, 0, 0); #1;
    chk("sh_fwd_rt", fwd_rt_a, S_E);
    chk("sh_stall", stall_a, 0);
    tick(); drain();
    setd(1, 0, 7, 0, 7, 1, 0, 2); tick();
    setd(1, 0, 0, 0, 7, 0, 0, 0); #1;
    chk("z0_stall", stall_a, 0);
    chk("z0_fwd", fwd_rs_a, 0);
    tick(); drain();

    // flush during stall
    setd(1, 0, 7, 0, 7, 1, 2, 2); tick();
    setd(1, 2, 0, 0, 7, 0, 0, 0); flush = 1'b1; #1;
    chk("fl_stall_pre", stall_a, 1);
    chk("fl_cnt_pre", cnt_a, 2);
    tick(); flush = 1'b0; #1;
    chk("fl_stall_post", stall_a, 0);
    chk("fl_cnt_post_a", cnt_a, 2);
    chk("fl_cnt_post_b", cnt_b, 2);
    tick(); drain();

    // unused operand
    setd(1, 0, 7, 0, 7, 1, 4, 2); tick();
    setd(1, 0, 7, 4, 7, 0, 0, 0); #1;
    chk("un_stall", stall_a, 0);
    chk("un_fwd_rt", fwd_rt_a, 0);
    tick(); drain();

    // asynchronous reset mid-stall
    setd(1, 0, 7, 0, 7, 1, 6, 3); tick();
    setd(1, 6, 0, 0, 7, 0, 0, 0); #1;
    chk("ar_stall_pre", stall_a, 1);
    tick(); #1;
    chk("ar_cnt_pre_a", cnt_a, 3);
    chk("ar_cnt_pre_b", cnt_b, 3);
    #1 rst_n = 1'b0;
    #1;
    chk("ar_stall_a", stall_a, 0);
    chk("ar_stall_b", stall_b, 0);
    chk("ar_fwd_a", fwd_rs_a, 0);
    chk("ar_cnt_a", cnt_a, 0);
    chk("ar_cnt_b", cnt_b, 0);
    #2 rst_n = 1'b1;
    idle();
    tick();

    // mixed vectors on a small register set, model-checked every cycle
    for (int i = 0; i < 80; i++) begin
      setd($urandom_range(0, 4) != 0, $urandom_range(0, 3), $urandom_range(0, 7),
           $urandom_range(0, 3), $urandom_range(0, 7), $urandom_range(0, 1) == 1,
           $urandom_range(0, 3), $urandom_range(0, 7));
      flush = ($urandom_range(0, 11) == 0);
      tick();
    end
    flush = 1'b0;
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
